// File: rtl/wb_gpio_arb.sv
// wb_gpio_arb -- two-master round-robin arbiter onto a single Wishbone slave.
//
// Ports:
//   clk, rst                  system clock (rising edge), async active-high reset
//   m0_* / m1_*               master ports: adr_i, dat_i, we_i, cyc_i, stb_i in;
//                             ack_o, err_o, dat_o out
//   s_*                       slave port: adr_o, dat_o, we_o, cyc_o, stb_o out;
//                             ack_i, dat_i in
//   gnt_o                     one-hot current owner (bit0 = m0, bit1 = m1), 00 idle
//   dbg_state_o               FSM state for observation (0 = IDLE, 1 = GRANT)
//
// Handshake: a master requests while cyc_i && stb_i are high. Once granted,
// the owner's signals pass straight to the slave; the transfer ends on the
// first cycle s_ack_i is high (owner sees ack_o), on timeout (owner sees one
// err_o pulse), or when the owner drops cyc_i (silent abort). The arbiter
// always returns to IDLE for one cycle between transfers, so s_cyc_o/s_stb_o
// go low between consecutive grants.
module wb_gpio_arb #(
  parameter int wb_dat_width   = 32,
  parameter int wb_adr_width   = 32,
  parameter int timeout_cycles = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [wb_adr_width-1:0] m0_adr_i,
  input  logic [wb_dat_width-1:0] m0_dat_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [wb_dat_width-1:0] m0_dat_o,
  input  logic [wb_adr_width-1:0] m1_adr_i,
  input  logic [wb_dat_width-1:0] m1_dat_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [wb_dat_width-1:0] m1_dat_o,
  output logic [wb_adr_width-1:0] s_adr_o,
  output logic [wb_dat_width-1:0] s_dat_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  input  logic [wb_dat_width-1:0] s_dat_i,
  output logic [1:0]              gnt_o,
  output logic                    dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [7:0] CNT_LAST = 8'(timeout_cycles - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic                    req0, req1, granted;
  logic                    own_cyc, own_stb, own_we;
  logic [wb_adr_width-1:0] own_adr;
  logic [wb_dat_width-1:0] own_dat;
  logic                    ack_ok, timeout;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign granted = (state_q == GRANT);

  // Owner's request signals, selected by the registered owner bit.
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
  assign own_we  = owner_q ? m1_we_i  : m0_we_i;
  assign own_adr = owner_q ? m1_adr_i : m0_adr_i;
  assign own_dat = owner_q ? m1_dat_i : m0_dat_i;

  // An ack is only honoured while the owner still holds cyc; ack beats timeout.
  assign ack_ok  = granted & own_cyc & s_ack_i;
  assign timeout = granted & own_cyc & ~s_ack_i & (cnt_q == CNT_LAST);

  assign s_adr_o = granted ? own_adr : '0;
  assign s_dat_o = granted ? own_dat : '0;
  assign s_we_o  = granted & own_we;
  assign s_cyc_o = granted & own_cyc;
  assign s_stb_o = granted & own_stb;

  assign m0_ack_o = ack_ok & ~owner_q;
  assign m1_ack_o = ack_ok & owner_q;
  assign m0_err_o = timeout & ~owner_q;
  assign m1_err_o = timeout & owner_q;
  assign m0_dat_o = (granted && !owner_q) ? s_dat_i : '0;
  assign m1_dat_o = (granted && owner_q)  ? s_dat_i : '0;

  assign gnt_o       = granted ? {owner_q, ~owner_q} : 2'b00;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // m0 wins the first tie
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          cnt_d   = '0;
          // Tie goes to whoever did not finish last; otherwise the sole requester.
          owner_d = (req0 && req1) ? ~last_q : req1;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_d = IDLE;  // abort: fairness history untouched
          cnt_d   = '0;
        end else if (s_ack_i || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_gpio_arb.sv
module tb_wb_gpio_arb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]    gnt_o;
  logic          dbg_state_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_gpio_arb #(.wb_dat_width(DW), .wb_adr_width(AW), .timeout_cycles(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1;
    rst = 1;
    #3;
    if (gnt_o !== 2'b00) begin $display("FAIL rst_gnt: got %b exp 00", gnt_o); n_bad++; end
    n_cmp++;
    if (dbg_state_o !== 1'b0) begin $display("FAIL rst_state: got %b exp 0", dbg_state_o); n_bad++; end
    n_cmp++;
    if ({s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 7'b0) begin
      $display("FAIL rst_ctl: got %b exp 0", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
      n_bad++;
    end
    n_cmp++;
    if ({m0_dat_o, m1_dat_o} !== 64'h0) begin $display("FAIL rst_dat: got %h exp 0", {m0_dat_o, m1_dat_o}); n_bad++; end
    n_cmp++;
    do_reset();
  endtask

  // Single m0 read with a registered-ack slave: GRANT c1, ack c2, IDLE c3.
  task automatic test_single_read();
    do_reset();
    tick();
    m0_adr_i = 32'h0; m0_we_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    #1;
    if (gnt_o !== 2'b00) begin $display("FAIL rd_c0_gnt: got %b exp 00", gnt_o); n_bad++; end
    n_cmp++;
    tick();
    if (gnt_o !== 2'b01) begin $display("FAIL rd_c1_gnt: got %b exp 01", gnt_o); n_bad++; end
    n_cmp++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110) begin $display("FAIL rd_c1_sctl: got %b exp 110", {s_cyc_o, s_stb_o, s_we_o}); n_bad++; end
    n_cmp++;
    if (m0_ack_o !== 1'b0) begin $display("FAIL rd_c1_ack: got %b exp 0", m0_ack_o); n_bad++; end
    n_cmp++;
    tick();
    s_ack_i = 1; s_dat_i = 32'h0000_000F;
    #1;
    if (gnt_o !== 2'b01) begin $display("FAIL rd_c2_gnt: got %b exp 01", gnt_o); n_bad++; end
    n_cmp++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h0F) begin
      $display("FAIL rd_c2_m0: got ack=%b dat=%h exp ack=1 dat=0000000f", m0_ack_o, m0_dat_o); n_bad++;
    end
    n_cmp++;
    if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
      $display("FAIL rd_c2_m1: got ack=%b dat=%h exp ack=0 dat=0", m1_ack_o, m1_dat_o); n_bad++;
    end
    n_cmp++;
    tick();
    idle_inputs();
    #1;
    if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin $display("FAIL rd_c3: got gnt=%b stb=%b exp 00/0", gnt_o, s_stb_o); n_bad++; end
    n_cmp++;
  endtask

  // Both masters hold requests; grants alternate m0, m1, m0 with an idle gap.
  task automatic test_round_robin();
    logic [1:0] exp_g[3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      s_ack_i = 1;
      #1;
      if (gnt_o !== exp_g[i]) begin $display("FAIL rr_gnt%0d: got %b exp %b", i, gnt_o, exp_g[i]); n_bad++; end
      n_cmp++;
      tick();
      s_ack_i = 0;
      #1;
      if (s_stb_o !== 1'b0 || gnt_o !== 2'b00) begin
        $display("FAIL rr_gap%0d: got stb=%b gnt=%b exp 0/00", i, s_stb_o, gnt_o); n_bad++;
      end
      n_cmp++;
    end
    idle_inputs();
  endtask

  // m1 write to a silent slave: one err pulse on the 16th GRANT cycle.
  task automatic test_timeout();
    int errs = 0;
    do_reset();
    m1_adr_i = 32'h4; m1_dat_i = 32'h5; m1_we_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    #1;
    if (s_adr_o !== 32'h4 || s_dat_o !== 32'h5 || s_we_o !== 1'b1) begin
      $display("FAIL to_route: got adr=%h dat=%h we=%b exp 4/5/1", s_adr_o, s_dat_o, s_we_o); n_bad++;
    end
    n_cmp++;
    for (int k = 1; k <= TO; k++) begin
      if (m1_err_o !== (k == TO)) begin $display("FAIL to_err_c%0d: got %b exp %b", k, m1_err_o, (k == TO)); n_bad++; end
      n_cmp++;
      if (m0_err_o) errs++;
      if (k < TO) tick();
      if (k < TO) #1;
    end
    tick();
    #1;
    if (s_stb_o !== 1'b0 || m1_err_o !== 1'b0) begin
      $display("FAIL to_after: got stb=%b err=%b exp 0/0", s_stb_o, m1_err_o); n_bad++;
    end
    n_cmp++;
    if (errs !== 0) begin $display("FAIL to_m0_err: got %0d cycles exp 0", errs); n_bad++; end
    n_cmp++;
    idle_inputs();
  endtask

  // Owner drops cyc: silent abort, pending m1 granted in cycle 3, and the
  // round-robin history is untouched.
  task automatic test_abort();
    int seen = 0;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
    #1;
    if (m0_ack_o || m0_err_o) seen++;
    tick();
    #1;
    if (m0_ack_o || m0_err_o) seen++;
    if (gnt_o !== 2'b00) begin $display("FAIL ab_c2_gnt: got %b exp 00", gnt_o); n_bad++; end
    n_cmp++;
    tick();
    #1;
    if (gnt_o !== 2'b10) begin $display("FAIL ab_c3_gnt: got %b exp 10", gnt_o); n_bad++; end
    n_cmp++;
    if (seen !== 0) begin $display("FAIL ab_no_resp: got %0d exp 0", seen); n_bad++; end
    n_cmp++;
    // Abort from reset, then a tie: last_owner is still m1, so m0 wins.
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    m0_cyc_i = 0;
    tick();
    m0_cyc_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    #1;
    if (gnt_o !== 2'b01) begin $display("FAIL ab_tie_gnt: got %b exp 01", gnt_o); n_bad++; end
    n_cmp++;
    idle_inputs();
  endtask

  // Ack on the timeout cycle: ack wins, no err.
  task automatic test_ack_timeout_coincide();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int k = 0; k < TO; k++) tick();
    s_ack_i = 1;
    #1;
    if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0) begin
      $display("FAIL co_resp: got ack=%b err=%b exp 1/0", m0_ack_o, m0_err_o); n_bad++;
    end
    n_cmp++;
    idle_inputs();
    tick();
  endtask

  // Slave ack while idle reaches nobody.
  task automatic test_idle_ack();
    do_reset();
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    if ({m0_ack_o, m1_ack_o} !== 2'b00 || {m0_dat_o, m1_dat_o} !== 64'h0) begin
      $display("FAIL idle_ack: got acks=%b exp 00", {m0_ack_o, m1_ack_o}); n_bad++;
    end
    n_cmp++;
    idle_inputs();
  endtask

  // Reset in the middle of a grant clears outputs without an edge.
  task automatic test_mid_reset();
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h8;
    tick();
    s_ack_i = 1; s_dat_i = 32'hA5A5_A5A5;
    #1;
    if (gnt_o !== 2'b10) begin $display("FAIL mr_pre_gnt: got %b exp 10", gnt_o); n_bad++; end
    n_cmp++;
    #1;
    rst = 1;
    #1;
    if (gnt_o !== 2'b00 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || s_adr_o !== 32'h0) begin
      $display("FAIL mr_out: got gnt=%b stb=%b cyc=%b adr=%h exp 0", gnt_o, s_stb_o, s_cyc_o, s_adr_o); n_bad++;
    end
    n_cmp++;
    if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
      $display("FAIL mr_m1: got ack=%b dat=%h exp 0/0", m1_ack_o, m1_dat_o); n_bad++;
    end
    n_cmp++;
    idle_inputs();
    tick();
    rst = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    #1;
    if (gnt_o !== 2'b01) begin $display("FAIL mr_tie: got %b exp 01", gnt_o); n_bad++; end
    n_cmp++;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_abort();
    test_ack_timeout_coincide();
    test_idle_ack();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_gpio_arb.md
WB_GPIO_ARB -- requirements
Module: wb_gpio_arb

Interface
REQ-001 The block SHALL provide parameter wb_dat_width, default 32, Wishbone data width.
REQ-002 The block SHALL provide parameter wb_adr_width, default 32, Wishbone address width.
REQ-003 The block SHALL provide parameter timeout_cycles, default 16, maximum GRANT cycles without slave ack; legal range 2..255.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, on the following ports: clk input 1 (system clock, rising edge) and rst input 1 (asynchronous active-high reset).
REQ-005 Each master port set m0_* and m1_* SHALL have adr_i input wb_adr_width, dat_i input wb_dat_width, we_i input 1, cyc_i input 1, stb_i input 1, ack_o output 1, err_o output 1 and dat_o output wb_dat_width.
REQ-006 The slave port set SHALL have s_adr_o output wb_adr_width, s_dat_o output wb_dat_width, s_we_o output 1, s_cyc_o output 1, s_stb_o output 1, s_ack_i input 1 and s_dat_i input wb_dat_width.
REQ-007 The block SHALL drive gnt_o, an output 2 bits wide, as a one-hot current owner: bit0 = m0, bit1 = m1, and 00 when idle.

Function
REQ-008 A master SHALL be requesting when both its cyc_i and stb_i are high.
REQ-009 The FSM SHALL have two states, IDLE and GRANT, plus a registered owner bit and a last_owner bit.
REQ-010 In IDLE with exactly one master requesting, the FSM SHALL enter GRANT with that master as owner at the next edge.
REQ-011 In IDLE with both masters requesting, the FSM SHALL grant the master that is not last_owner (round-robin).
REQ-012 In IDLE with no master requesting, the FSM SHALL remain in IDLE.
REQ-013 In GRANT, s_adr_o, s_dat_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally follow the owner's inputs; in IDLE they SHALL all be 0.
REQ-014 In GRANT, the owner's ack_o SHALL equal s_ack_i and its dat_o SHALL equal s_dat_i; the non-owner's ack_o, err_o and dat_o SHALL be 0.
REQ-015 When s_ack_i is high in GRANT, the FSM SHALL set last_owner to owner and return to IDLE at the next edge, forcing s_stb_o and s_cyc_o low for at least one cycle between transfers.
REQ-016 The cycle counter SHALL clear on entry to GRANT and increment each GRANT cycle without s_ack_i.
REQ-017 When the counter reaches timeout_cycles-1 without s_ack_i, the block SHALL pulse the owner's err_o high for exactly that cycle, set last_owner, and return to IDLE.
REQ-018 If the owner drops cyc_i while in GRANT, the block SHALL abort to IDLE at the next edge without ack_o or err_o and SHALL leave last_owner unchanged.
REQ-019 If s_ack_i and the timeout coincide in the same cycle, ack SHALL win and err_o SHALL stay 0.
REQ-020 A master request arriving in GRANT SHALL wait and is eligible on the first IDLE cycle.
REQ-021 Latency with a slave that registers its ack: request in cycle 0 (IDLE), GRANT in cycle 1, ack_o high in cycle 2, IDLE in cycle 3.
REQ-022 The block SHALL pass s_ack_i asserted while in IDLE to no master.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, owner=0, last_owner=1 (so m0 wins the first tie), counter=0 and gnt_o=00.
REQ-024 During reset, all outputs SHALL be 0, including the s_* outputs and both masters' ack_o, err_o and dat_o.
REQ-025 Reset asserted mid-GRANT SHALL abandon the transfer without ack_o or err_o to either master.

Verification
REQ-026 m0 read only, adr=0x0, slave returns 0x0000000F with ack in cycle 2 -> gnt_o=01 in cycles 1-2, m0_ack_o=1 and m0_dat_o=0x0F in cycle 2, gnt_o=00 in cycle 3.
REQ-027 m0 and m1 request together from reset -> m0 granted first; both held requesting -> m1 granted next, then m0 (strict alternation); s_stb_o low one cycle between grants.
REQ-028 m1 write adr=0x4, dat=0x5, slave never acks, timeout_cycles=16 -> m1_err_o=1 for exactly one cycle, 16th GRANT cycle; s_stb_o=0 next cycle; m0_err_o stays 0.
REQ-029 m0 granted, drops cyc_i in cycle 1 -> IDLE in cycle 2, no ack_o/err_o; a pending m1 request is granted in cycle 3.
REQ-030 rst pulsed mid-GRANT -> all outputs 0 without a clock edge; after release a tie grants m0.
